// File: rtl/spi_cmd_master.sv
// spi_cmd_master: SPI master that sends a CMD_BITS command and then reads back
// an RX_BITS response inside a single chip-select frame. The SPI mode (CPOL/CPHA)
// and the SCLK divider are fixed when the block is built. Every pin is driven
// from a register, and SCLK is produced by a toggling flop, never by gating clk.
module spi_cmd_master #(
  parameter int CMD_BITS = 8,
  parameter int RX_BITS  = 24,
  parameter int CLK_DIV  = 2,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CMD_BITS-1:0] cmd,
  output logic                busy,
  output logic                done,
  output logic [RX_BITS-1:0]  rx_data,
  output logic                SPICS_N,
  output logic                SPICLK,
  output logic                SPIMOSI,
  input  logic                SPIMISO
);

  localparam int TOTAL = CMD_BITS + RX_BITS;
  localparam int TICKS = 2 * TOTAL;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TCK_W = $clog2(TICKS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [TCK_W-1:0] TCK_LAST  = TCK_W'(TICKS - 1);
  // Ticks 0 .. 2*CMD_BITS-1 cover the command bits. A MISO sample taken
  // during those ticks belongs to the command phase and is thrown away.
  localparam logic [TCK_W-1:0] CMD_TICKS = TCK_W'(2 * CMD_BITS);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_DEASSERT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DIV_W-1:0]   r_div;
  logic [DIV_W-1:0]   w_div_nxt;
  logic [TCK_W-1:0]   r_tck;
  logic [TCK_W-1:0]   w_tck_nxt;
  logic [TOTAL-1:0]   r_tx;
  logic [TOTAL-1:0]   w_tx_nxt;
  logic [RX_BITS-1:0] r_rx;
  logic [RX_BITS-1:0] w_rx_nxt;
  logic [RX_BITS-1:0] r_rx_data;
  logic [RX_BITS-1:0] w_rx_data_nxt;
  logic               r_sclk;
  logic               w_sclk_nxt;
  logic               r_mosi;
  logic               w_mosi_nxt;
  logic               r_cs_n;
  logic               w_cs_n_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_done;
  logic               w_done_nxt;

  logic               w_tick;
  logic               w_lead;
  logic               w_sample;
  logic [RX_BITS:0]   w_rx_shift;
  logic [TOTAL-1:0]   w_tx_shift;

  assign w_tick     = (r_div == DIV_LAST);
  // Even tick count is the first toggle of a bit, which is its leading edge.
  assign w_lead     = ~r_tck[0];
  // Leading edge samples when CPHA=0. Trailing edge samples when CPHA=1.
  assign w_sample   = w_lead ^ CPHA;
  assign w_rx_shift = {r_rx, SPIMISO};
  assign w_tx_shift = {r_tx[TOTAL-2:0], 1'b0};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-value logic for the divider, the shifters and the pins.
  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = w_tick ? '0 : (r_div + DIV_W'(1));
    w_tck_nxt     = r_tck;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_rx_data_nxt = r_rx_data;
    w_sclk_nxt    = r_sclk;
    w_mosi_nxt    = r_mosi;
    w_cs_n_nxt    = r_cs_n;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_div_nxt  = '0;
        w_tck_nxt  = '0;
        w_sclk_nxt = CPOL;
        // Ignore start during the done cycle. This keeps CS high between frames.
        if (start && !r_done) begin
          w_tx_nxt    = {cmd, {RX_BITS{1'b0}}};
          w_rx_nxt    = '0;
          w_busy_nxt  = 1'b1;
          w_cs_n_nxt  = 1'b0;
          w_mosi_nxt  = CPHA ? 1'b0 : cmd[CMD_BITS-1];
          w_state_nxt = ST_ASSERT;
        end else begin
          w_busy_nxt  = 1'b0;
          w_cs_n_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_ASSERT: begin
        if (w_tick) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_ASSERT;
        end
      end

      ST_SHIFT: begin
        if (w_tick) begin
          w_sclk_nxt = ~r_sclk;
          w_tck_nxt  = r_tck + TCK_W'(1);
          if (w_sample) begin
            if (r_tck >= CMD_TICKS) begin
              w_rx_nxt = w_rx_shift[RX_BITS-1:0];
            end else begin
              w_rx_nxt = r_rx;
            end
          end else begin
            // Launch the next MOSI bit. When CPHA=1 the current MSB goes
            // out now. When CPHA=0 the MSB already went out, so present the next one.
            w_tx_nxt   = w_tx_shift;
            w_mosi_nxt = CPHA ? r_tx[TOTAL-1] : w_tx_shift[TOTAL-1];
          end
          if (r_tck == TCK_LAST) begin
            w_tck_nxt   = '0;
            w_state_nxt = ST_DEASSERT;
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end

      ST_DEASSERT: begin
        w_sclk_nxt = CPOL;
        if (w_tick) begin
          w_cs_n_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_rx_data_nxt = r_rx;
          w_mosi_nxt    = 1'b0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_state_nxt   = ST_DEASSERT;
        end
      end

      default: begin
        w_div_nxt   = '0;
        w_tck_nxt   = '0;
        w_sclk_nxt  = CPOL;
        w_mosi_nxt  = 1'b0;
        w_cs_n_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div     <= '0;
      r_tck     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_sclk    <= CPOL;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_div     <= w_div_nxt;
      r_tck     <= w_tck_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_rx_data <= w_rx_data_nxt;
      r_sclk    <= w_sclk_nxt;
      r_mosi    <= w_mosi_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign SPICS_N = r_cs_n;
  assign SPICLK  = r_sclk;
  assign SPIMOSI = r_mosi;

endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: directed bench driving six spi_cmd_master builds
// (modes 0/3/1/2 at CLK_DIV=2 with 8/24 bits, plus CLK_DIV=1 and 5 with 8/8 bits),
// each connected to a small flash responder model.
module tb_spi_cmd_master;

  localparam int NI = 6;

  function automatic int cfg_div(input int g);
    case (g)
      4:       return 1;
      5:       return 5;
      default: return 2;
    endcase
  endfunction

  function automatic int cfg_rx(input int g);
    case (g)
      4, 5:    return 8;
      default: return 24;
    endcase
  endfunction

  function automatic bit cfg_cpol(input int g);
    case (g)
      1, 3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit cfg_cpha(input int g);
    case (g)
      1, 2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  start_v;
  logic [7:0]  cmd;
  logic [5:0]  busy_v, done_v, cs_v, sclk_v, mosi_v;
  logic [23:0] rx_v   [NI];
  logic [23:0] resp_v [NI];
  int          pulses_v [NI];
  logic [31:0] mcap_v [NI];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int RXB = cfg_rx(g);
    localparam int TOT = 8 + RXB;
    localparam bit PHA = cfg_cpha(g);

    logic [RXB-1:0] rx_l;
    logic           miso_l;
    logic [TOT-1:0] frame_l;
    logic [31:0]    mcap = 32'h0;
    int             tog  = 0;
    int             base = 0;
    int             e_l;
    int             idx;

    spi_cmd_master #(
      .CMD_BITS(8), .RX_BITS(RXB), .CLK_DIV(cfg_div(g)),
      .CPOL(cfg_cpol(g)), .CPHA(cfg_cpha(g))
    ) u_dut (
      .clk(clk), .reset(reset), .start(start_v[g]), .cmd(cmd),
      .busy(busy_v[g]), .done(done_v[g]), .rx_data(rx_l),
      .SPICS_N(cs_v[g]), .SPICLK(sclk_v[g]), .SPIMOSI(mosi_v[g]), .SPIMISO(miso_l)
    );

    assign rx_v[g]     = 24'(rx_l);
    assign e_l         = tog - base;
    assign pulses_v[g] = e_l / 2;
    assign mcap_v[g]   = mcap;
    assign frame_l     = {8'h00, resp_v[g][RXB-1:0]};

    // Flash responder: drive the bit that the master samples at its next sampling edge.
    always_comb begin
      idx    = PHA ? ((e_l > 0) ? (e_l - 1) / 2 : 0) : e_l / 2;
      miso_l = 1'b0;
      if (idx < TOT) miso_l = frame_l[TOT-1-idx];
    end

    // Count SCLK edges and capture MOSI at the slave's sampling edge.
    always @(sclk_v[g]) begin
      tog <= tog + 1;
      if (((e_l % 2) == 1) == PHA) mcap <= {mcap[30:0], mosi_v[g]};
    end

    // Restart the edge count when chip select falls.
    always @(negedge cs_v[g]) base <= tog;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge. Returns the cycle on which done is seen (1 = first cycle after accept).
  task automatic frame(input int g, input logic [7:0] c, input logic [23:0] r,
                       output int lat, output logic busy1);
    resp_v[g]  = r;
    cmd        = c;
    start_v[g] = 1'b1;
    lat        = 0;
    busy1      = 1'b0;
    repeat (4000) begin
      @(negedge clk);
      lat++;
      start_v[g] = 1'b0;
      if (lat == 1) busy1 = busy_v[g];
      if (done_v[g]) break;
    end
  endtask

  task automatic frame_chk(input int g, input string nm, input logic [7:0] c,
                           input logic [23:0] r, input int exp_lat,
                           input logic [31:0] exp_mcap, input logic [31:0] mmask);
    int   lat;
    logic b1;
    frame(g, c, r, lat, b1);
    chk({nm, "_lat"},    32'(lat), 32'(exp_lat));
    chk({nm, "_rx"},     32'(rx_v[g]), 32'(r));
    chk({nm, "_busy1"},  32'(b1), 32'd1);
    chk({nm, "_busy0"},  32'(busy_v[g]), 32'd0);
    chk({nm, "_csn"},    32'(cs_v[g]), 32'd1);
    chk({nm, "_sclk"},   32'(sclk_v[g]), 32'(cfg_cpol(g)));
    chk({nm, "_pulses"}, 32'(pulses_v[g]), 32'(8 + cfg_rx(g)));
    chk({nm, "_mosi"},   mcap_v[g] & mmask, exp_mcap);
    @(negedge clk);
    chk({nm, "_done1"},  32'(done_v[g]), 32'd0);
  endtask

  initial begin
    int   dn;
    int   gap;
    bit   in_gap;
    logic [23:0] rx1, rx2;

    reset   = 1'b1;
    start_v = 6'b0;
    cmd     = 8'h00;
    for (int i = 0; i < NI; i++) resp_v[i] = 24'h0;
    repeat (2) @(negedge clk);

    chk("rst_csn",   32'(cs_v[0]), 32'd1);
    chk("rst_sclk0", 32'(sclk_v[0]), 32'd0);
    chk("rst_sclk3", 32'(sclk_v[1]), 32'd1);
    chk("rst_busy",  32'(busy_v[0]), 32'd0);
    chk("rst_done",  32'(done_v[0]), 32'd0);
    chk("rst_rx",    32'(rx_v[0]), 32'd0);
    chk("rst_mosi",  32'(mosi_v[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Mode 0 RDID
    frame_chk(0, "m0", 8'h9F, 24'hEF4018, 133, 32'h9F000000, 32'hFFFFFFFF);
    // Mode 3 / mode 1 / mode 2
    frame_chk(1, "m3", 8'h9F, 24'hEF4018, 133, 32'h9F000000, 32'hFFFFFFFF);
    frame_chk(2, "m1", 8'h9F, 24'hA5A5A5, 133, 32'h9F000000, 32'hFFFFFFFF);
    frame_chk(3, "m2", 8'h9F, 24'hA5A5A5, 133, 32'h9F000000, 32'hFFFFFFFF);
    // Divider extremes, 8/8 bits: 1+2*DIV*17
    frame_chk(4, "d1", 8'h05, 24'h00003C, 35,  32'h00000500, 32'h0000FFFF);
    frame_chk(5, "d5", 8'h05, 24'h00003C, 171, 32'h00000500, 32'h0000FFFF);

    // Start pulsed while busy and cmd changed mid-frame
    resp_v[0]  = 24'h123456;
    cmd        = 8'h3A;
    start_v[0] = 1'b1;
    dn         = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) cmd = 8'hC5;
      start_v[0] = (n == 10 || n == 40 || n == 80);
      if (done_v[0]) dn++;
    end
    chk("busy_done_cnt", 32'(dn), 32'd1);
    chk("busy_rx",       32'(rx_v[0]), 32'h123456);
    chk("busy_mosi",     mcap_v[0], 32'h3A000000);

    // Reset mid-frame, during the high phase of pulse 13
    resp_v[0]  = 24'hEF4018;
    cmd        = 8'h9F;
    start_v[0] = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (pulses_v[0] == 12 && sclk_v[0] == 1'b1) break;
    end
    chk("mid_reach", 32'(pulses_v[0]), 32'd12);
    chk("mid_held",  32'(rx_v[0]), 32'h123456);
    reset = 1'b1;
    #1;
    chk("mid_csn",  32'(cs_v[0]), 32'd1);
    chk("mid_sclk", 32'(sclk_v[0]), 32'd0);
    chk("mid_busy", 32'(busy_v[0]), 32'd0);
    chk("mid_rx",   32'(rx_v[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dn    = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done_v[0]) dn++;
    end
    chk("mid_nodone", 32'(dn), 32'd0);
    frame_chk(0, "post", 8'h9F, 24'hEF4018, 133, 32'h9F000000, 32'hFFFFFFFF);

    // Start held high: back-to-back frames
    resp_v[0]  = 24'hEF4018;
    cmd        = 8'h9F;
    start_v[0] = 1'b1;
    dn = 0; gap = 0; in_gap = 1'b0; rx1 = '0; rx2 = '0;
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      if (done_v[0]) begin
        dn++;
        if (dn == 1) begin
          rx1       = rx_v[0];
          resp_v[0] = 24'h5A5A5A;
          in_gap    = 1'b1;
        end else begin
          rx2 = rx_v[0];
          break;
        end
      end
      if (in_gap) begin
        if (cs_v[0]) gap++;
        else in_gap = 1'b0;
      end
    end
    start_v[0] = 1'b0;
    chk("b2b_dones", 32'(dn), 32'd2);
    chk("b2b_rx1",   32'(rx1), 32'hEF4018);
    chk("b2b_rx2",   32'(rx2), 32'h5A5A5A);
    chk("b2b_gap",   32'(gap >= 1), 32'd1);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
